// File: rtl/pc_gen.sv
// ---------------------------------------------------------------------------
// pc_gen -- fetch PC generator for the RV32I front end.
//
// Holds the registered fetch PC and chooses the next PC from four sources.
// Highest priority first:
//   1. EX-stage redirect (flush). It wins even over a stall.
//   2. stall[0], which holds the PC.
//   3. ID-stage jump.
//   4. BTB prediction.
//   5. Sequential PC + STEP. This wraps modulo 2^ADDR_W.
//
// The BTB is direct-mapped and holds BTB_DEPTH entries. Each entry carries
// a tag, a target and a 2-bit saturating counter. EX-stage branch
// resolution trains it.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   stall[STALL_W-1:0]   pipeline stall vector; only bit 0 freezes the PC
//   ex_redirect(_addr)   EX flush and its corrected PC
//   ex_upd, ex_upd_pc, ex_upd_target, ex_upd_taken
//                        BTB training from EX branch resolution
//   id_jump(_addr)       ID-stage JAL and its target
//   pc                   registered fetch PC
//   chip_enable          registered fetch enable, 1 from the first edge
//                        after reset
//   pred_taken           combinational BTB taken prediction for pc
//   pred_target          combinational predicted target (0 when not taken)
// ---------------------------------------------------------------------------
module pc_gen #(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter int              STEP      = 4,
  parameter int              STALL_W   = 6,
  parameter bit              BTB_EN    = 1'b1,
  parameter int              BTB_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STALL_W-1:0] stall,
  input  logic              ex_redirect,
  input  logic [ADDR_W-1:0] ex_redirect_addr,
  input  logic              ex_upd,
  input  logic [ADDR_W-1:0] ex_upd_pc,
  input  logic [ADDR_W-1:0] ex_upd_target,
  input  logic              ex_upd_taken,
  input  logic              id_jump,
  input  logic [ADDR_W-1:0] id_jump_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              chip_enable,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target
);

  localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

  logic [ADDR_W-1:0] pc_next;

  // Only stall[0] matters to this block. The rest of the vector belongs
  // to other stages.
  logic unused_stall;
  assign unused_stall = ^stall;

  // Next-PC selection. A flush is checked before the stall on purpose:
  // squashing a wrong path must not wait for a stall to clear.
  always_comb begin
    pc_next = pc;
    if (ex_redirect) begin
      pc_next = ex_redirect_addr;
    end else if (stall[0]) begin
      pc_next = pc;
    end else if (id_jump) begin
      pc_next = id_jump_addr;
    end else if (pred_taken) begin
      pc_next = pred_target;
    end else begin
      pc_next = pc + STEP_V;
    end
  end

  // chip_enable rises on the first edge out of reset. On that edge the PC
  // still holds RESET_VEC, and every steering input is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_VEC;
      chip_enable <= 1'b0;
    end else begin
      chip_enable <= 1'b1;
      if (chip_enable) begin
        pc <= pc_next;
      end
    end
  end

  if (BTB_EN) begin : g_btb
    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    logic [BTB_DEPTH-1:0] btb_valid;
    logic [TAG_W-1:0]     btb_tag    [BTB_DEPTH];
    logic [ADDR_W-1:0]    btb_target [BTB_DEPTH];
    logic [1:0]           btb_cnt    [BTB_DEPTH];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    // Instructions are word aligned, so the two LSBs of the resolved PC
    // play no part in indexing or tagging.
    logic unused_upd_lsb;
    assign unused_upd_lsb = ^ex_upd_pc[1:0];

    assign lk_idx = pc[IDX_W+1:2];
    assign lk_tag = pc[ADDR_W-1:IDX_W+2];
    assign lk_hit = btb_valid[lk_idx] && (btb_tag[lk_idx] == lk_tag);

    assign up_idx = ex_upd_pc[IDX_W+1:2];
    assign up_tag = ex_upd_pc[ADDR_W-1:IDX_W+2];
    assign up_hit = btb_valid[up_idx] && (btb_tag[up_idx] == up_tag);

    // The lookup reads the registered array directly. A training write
    // to the same index becomes visible only after the edge (no bypass).
    assign pred_taken  = chip_enable && lk_hit && btb_cnt[lk_idx][1];
    assign pred_target = pred_taken ? btb_target[lk_idx] : '0;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        btb_valid <= '0;
        for (int i = 0; i < BTB_DEPTH; i++) begin
          btb_tag[i]    <= '0;
          btb_target[i] <= '0;
          btb_cnt[i]    <= 2'b01;
        end
      end else if (chip_enable && ex_upd) begin
        if (up_hit) begin
          if (ex_upd_taken) begin
            if (btb_cnt[up_idx] != 2'b11) begin
              btb_cnt[up_idx] <= btb_cnt[up_idx] + 2'b01;
            end
            btb_target[up_idx] <= ex_upd_target;
          end else if (btb_cnt[up_idx] != 2'b00) begin
            btb_cnt[up_idx] <= btb_cnt[up_idx] - 2'b01;
          end
        end else if (ex_upd_taken) begin
          // A taken branch that misses takes over the slot, even if
          // another branch with a different tag lives there. It starts
          // as weakly taken.
          btb_valid[up_idx]  <= 1'b1;
          btb_tag[up_idx]    <= up_tag;
          btb_target[up_idx] <= ex_upd_target;
          btb_cnt[up_idx]    <= 2'b10;
        end
      end
    end
  end else begin : g_no_btb
    logic unused_btb_in;
    assign unused_btb_in = ^{ex_upd, ex_upd_pc, ex_upd_target, ex_upd_taken};
    assign pred_taken    = 1'b0;
    assign pred_target   = '0;
  end

endmodule

// File: tb/tb_pc_gen.sv
// ---------------------------------------------------------------------------
// tb_pc_gen -- self-checking bench for pc_gen (default parameters:
// RESET_VEC=0, STEP=4, BTB_DEPTH=16). The expected PC for each edge goes
// into exp_q when the stimulus is driven. It is popped and compared once
// the edge has happened.
// ---------------------------------------------------------------------------
module tb_pc_gen;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [5:0]    stall;
  logic          ex_redirect;
  logic [AW-1:0] ex_redirect_addr;
  logic          ex_upd;
  logic [AW-1:0] ex_upd_pc;
  logic [AW-1:0] ex_upd_target;
  logic          ex_upd_taken;
  logic          id_jump;
  logic [AW-1:0] id_jump_addr;
  logic [AW-1:0] pc;
  logic          chip_enable;
  logic          pred_taken;
  logic [AW-1:0] pred_target;

  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] exp_v;
  logic [AW-1:0] exp_pc;
  int            n_cmp = 0;
  int            n_err = 0;

  pc_gen dut (
    .clk              (clk),
    .rst              (rst),
    .stall            (stall),
    .ex_redirect      (ex_redirect),
    .ex_redirect_addr (ex_redirect_addr),
    .ex_upd           (ex_upd),
    .ex_upd_pc        (ex_upd_pc),
    .ex_upd_target    (ex_upd_target),
    .ex_upd_taken     (ex_upd_taken),
    .id_jump          (id_jump),
    .id_jump_addr     (id_jump_addr),
    .pc               (pc),
    .chip_enable      (chip_enable),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall            = '0;
    ex_redirect      = 1'b0;
    ex_redirect_addr = '0;
    ex_upd           = 1'b0;
    ex_upd_pc        = '0;
    ex_upd_target    = '0;
    ex_upd_taken     = 1'b0;
    id_jump          = 1'b0;
    id_jump_addr     = '0;
  endtask

  task automatic drive_redirect(input logic [AW-1:0] a);
    ex_redirect      = 1'b1;
    ex_redirect_addr = a;
  endtask

  task automatic drive_train(input logic [AW-1:0] p, input logic tk,
                             input logic [AW-1:0] tgt);
    ex_upd        = 1'b1;
    ex_upd_pc     = p;
    ex_upd_taken  = tk;
    ex_upd_target = tgt;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (pc !== 32'h0 || chip_enable !== 1'b0 || pred_taken !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: pc=%h ce=%b pt=%b, expected pc=0 ce=0 pt=0",
               pc, chip_enable, pred_taken);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (chip_enable !== 1'b0) begin
      n_err++;
      $display("FAIL ce_before_edge: ce=%b expected 0", chip_enable);
    end
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (pc !== exp_v) begin
        n_err++;
        $display("FAIL reset_release[%0d]: pc=%h expected %h", i, pc, exp_v);
      end
      if (i == 0) begin
        n_cmp++;
        if (chip_enable !== 1'b1) begin
          n_err++;
          $display("FAIL ce_first_edge: ce=%b expected 1", chip_enable);
        end
      end
    end
  endtask

  // pc = 0x8 on entry
  task automatic test_stall_redirect();
    stall[0] = 1'b1;
    id_jump = 1'b1;
    id_jump_addr = 32'h100;
    exp_q.push_back(32'h8);
    tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (pc !== exp_v) begin
      n_err++;
      $display("FAIL stall_hold: pc=%h expected %h", pc, exp_v);
    end
    drive_redirect(32'h200);
    exp_q.push_back(32'h200);
    tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (pc !== exp_v) begin
      n_err++;
      $display("FAIL flush_over_stall: pc=%h expected %h", pc, exp_v);
    end
    idle_inputs();
    exp_q.push_back(32'h204);
    tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (pc !== exp_v) begin
      n_err++;
      $display("FAIL after_flush: pc=%h expected %h", pc, exp_v);
    end
  endtask

  // pc = 0x204 on entry
  task automatic test_priority();
    drive_train(32'h208, 1'b1, 32'h500);
    exp_q.push_back(32'h208);
    tick();
    idle_inputs();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (pc !== exp_v || pred_taken !== 1'b1 || pred_target !== 32'h500) begin
      n_err++;
      $display("FAIL btb_hit_0x208: pc=%h pt=%b tgt=%h expected pc=%h pt=1 tgt=500",
               pc, pred_taken, pred_target, exp_v);
    end
    id_jump = 1'b1;
    id_jump_addr = 32'h80;
    exp_q.push_back(32'h80);
    tick();
    idle_inputs();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (pc !== exp_v) begin
      n_err++;
      $display("FAIL jump_over_pred: pc=%h expected %h", pc, exp_v);
    end
    drive_redirect(32'h208);
    exp_q.push_back(32'h208);
    tick();
    exp_v = exp_q.pop_front();
    drive_redirect(32'h40);
    id_jump = 1'b1;
    id_jump_addr = 32'h80;
    n_cmp++;
    if (pc !== exp_v || pred_taken !== 1'b1) begin
      n_err++;
      $display("FAIL hit_before_prio: pc=%h pt=%b expected pc=%h pt=1", pc, pred_taken, exp_v);
    end
    exp_q.push_back(32'h40);
    tick();
    idle_inputs();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (pc !== exp_v) begin
      n_err++;
      $display("FAIL redirect_wins: pc=%h expected %h", pc, exp_v);
    end
  endtask

  // pc = 0x40 on entry
  task automatic test_btb_learning();
    logic        tr_tk  [8];
    logic [31:0] tr_tgt [8];
    exp_pc = 32'h40;
    drive_train(32'h10, 1'b1, 32'h300);
    exp_pc = exp_pc + 4;
    exp_q.push_back(exp_pc);
    tick();
    idle_inputs();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (pc !== exp_v) begin
      n_err++;
      $display("FAIL learn_seq: pc=%h expected %h", pc, exp_v);
    end
    drive_redirect(32'h10);
    tick();
    idle_inputs();
    n_cmp++;
    if (pc !== 32'h10 || pred_taken !== 1'b1 || pred_target !== 32'h300) begin
      n_err++;
      $display("FAIL learn_pred: pc=%h pt=%b tgt=%h expected pc=10 pt=1 tgt=300",
               pc, pred_taken, pred_target);
    end
    exp_q.push_back(32'h300);
    tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (pc !== exp_v) begin
      n_err++;
      $display("FAIL pred_follow: pc=%h expected %h", pc, exp_v);
    end
    // Train not-taken twice: cnt 2 -> 1 -> 0.
    exp_pc = 32'h300;
    for (int i = 0; i < 2; i++) begin
      drive_train(32'h10, 1'b0, 32'h999);
      exp_pc = exp_pc + 4;
      exp_q.push_back(exp_pc);
      tick();
      idle_inputs();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (pc !== exp_v) begin
        n_err++;
        $display("FAIL nt_train_seq[%0d]: pc=%h expected %h", i, pc, exp_v);
      end
    end
    drive_redirect(32'h10);
    tick();
    idle_inputs();
    n_cmp++;
    if (pc !== 32'h10 || pred_taken !== 1'b0 || pred_target !== 32'h0) begin
      n_err++;
      $display("FAIL nt_pred_off: pc=%h pt=%b tgt=%h expected pc=10 pt=0 tgt=0",
               pc, pred_taken, pred_target);
    end
    exp_q.push_back(32'h14);
    tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (pc !== exp_v) begin
      n_err++;
      $display("FAIL seq_after_nt: pc=%h expected %h", pc, exp_v);
    end
    // cnt 0: NT holds at 0, then T -> 1 (still not predicted).
    tr_tk[0] = 1'b0; tr_tgt[0] = 32'h999;
    tr_tk[1] = 1'b1; tr_tgt[1] = 32'h320;
    // Then T,T,T saturate at 3, and NT -> 2 (predicted, target unchanged).
    tr_tk[2] = 1'b1; tr_tgt[2] = 32'h320;
    tr_tk[3] = 1'b1; tr_tgt[3] = 32'h330;
    tr_tk[4] = 1'b1; tr_tgt[4] = 32'h340;
    tr_tk[5] = 1'b0; tr_tgt[5] = 32'h999;
    exp_pc = 32'h14;
    for (int i = 0; i < 6; i++) begin
      drive_train(32'h10, tr_tk[i], tr_tgt[i]);
      exp_pc = exp_pc + 4;
      tick();
      idle_inputs();
      if (i == 1) begin
        drive_redirect(32'h10);
        tick();
        idle_inputs();
        n_cmp++;
        if (pc !== 32'h10 || pred_taken !== 1'b0) begin
          n_err++;
          $display("FAIL sat_low: pc=%h pt=%b expected pc=10 pt=0", pc, pred_taken);
        end
        exp_pc = 32'h10;
      end
    end
    drive_redirect(32'h10);
    tick();
    idle_inputs();
    n_cmp++;
    if (pc !== 32'h10 || pred_taken !== 1'b1 || pred_target !== 32'h340) begin
      n_err++;
      $display("FAIL sat_high: pc=%h pt=%b tgt=%h expected pc=10 pt=1 tgt=340",
               pc, pred_taken, pred_target);
    end
  endtask

  // 0x10 is valid at index 4. 0x50 and 0x90 alias to the same index.
  task automatic test_aliasing();
    drive_redirect(32'h400);
    tick();
    idle_inputs();
    drive_train(32'h50, 1'b1, 32'h600);
    tick();
    idle_inputs();
    drive_train(32'h90, 1'b0, 32'h700);
    tick();
    idle_inputs();
    drive_redirect(32'h10);
    tick();
    idle_inputs();
    n_cmp++;
    if (pc !== 32'h10 || pred_taken !== 1'b0) begin
      n_err++;
      $display("FAIL alias_evicted: pc=%h pt=%b expected pc=10 pt=0", pc, pred_taken);
    end
    exp_q.push_back(32'h14);
    tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (pc !== exp_v) begin
      n_err++;
      $display("FAIL alias_seq: pc=%h expected %h", pc, exp_v);
    end
    drive_redirect(32'h50);
    tick();
    idle_inputs();
    n_cmp++;
    if (pc !== 32'h50 || pred_taken !== 1'b1 || pred_target !== 32'h600) begin
      n_err++;
      $display("FAIL alias_new: pc=%h pt=%b tgt=%h expected pc=50 pt=1 tgt=600",
               pc, pred_taken, pred_target);
    end
    exp_q.push_back(32'h600);
    tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (pc !== exp_v) begin
      n_err++;
      $display("FAIL alias_follow: pc=%h expected %h", pc, exp_v);
    end
  endtask

  task automatic test_wrap_async();
    logic [31:0] probe [3];
    probe[0] = 32'h50;
    probe[1] = 32'h10;
    probe[2] = 32'h208;
    // A misaligned target passes through unchanged.
    drive_redirect(32'h103);
    exp_q.push_back(32'h103);
    tick();
    idle_inputs();
    exp_q.push_back(32'h107);
    for (int i = 0; i < 2; i++) begin
      if (i == 1) tick();
      exp_v = exp_q.pop_front();
      n_cmp++;
      if (pc !== exp_v) begin
        n_err++;
        $display("FAIL misaligned[%0d]: pc=%h expected %h", i, pc, exp_v);
      end
    end
    drive_redirect(32'hFFFF_FFFC);
    tick();
    idle_inputs();
    exp_q.push_back(32'h0);
    tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (pc !== exp_v) begin
      n_err++;
      $display("FAIL wrap: pc=%h expected %h", pc, exp_v);
    end
    drive_redirect(32'h50);
    tick();
    idle_inputs();
    n_cmp++;
    if (pred_taken !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_hit: pt=%b expected 1", pred_taken);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (pc !== 32'h0 || pred_taken !== 1'b0 || chip_enable !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset: pc=%h pt=%b ce=%b expected pc=0 pt=0 ce=0",
               pc, pred_taken, chip_enable);
    end
    tick();
    rst = 1'b0;
    // While chip_enable=0 these must be ignored.
    drive_redirect(32'h123);
    drive_train(32'h0, 1'b1, 32'h800);
    exp_q.push_back(32'h0);
    tick();
    idle_inputs();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (pc !== exp_v || chip_enable !== 1'b1 || pred_taken !== 1'b0) begin
      n_err++;
      $display("FAIL gated_inputs: pc=%h ce=%b pt=%b expected pc=%h ce=1 pt=0",
               pc, chip_enable, pred_taken, exp_v);
    end
    exp_q.push_back(32'h4);
    tick();
    exp_v = exp_q.pop_front();
    n_cmp++;
    if (pc !== exp_v) begin
      n_err++;
      $display("FAIL gated_seq: pc=%h expected %h", pc, exp_v);
    end
    for (int i = 0; i < 3; i++) begin
      drive_redirect(probe[i]);
      tick();
      idle_inputs();
      n_cmp++;
      if (pc !== probe[i] || pred_taken !== 1'b0) begin
        n_err++;
        $display("FAIL btb_cleared[%0d]: pc=%h pt=%b expected pc=%h pt=0",
                 i, pc, pred_taken, probe[i]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_stall_redirect();
    test_priority();
    test_btb_learning();
    test_aliasing();
    test_wrap_async();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised next-generation PC generator for the RV32I pipeline front end. It holds the fetch PC and feeds it to the IF stage. It supports a configurable reset vector and address width, and arbitrates three PC sources: the EX-stage redirect (flush), the ID-stage jump, and a small direct-mapped branch target buffer (BTB) with 2-bit saturating counters. The BTB is trained by EX-stage branch resolution.

Parameters:
ADDR_W, 32, PC and address width in bits.
RESET_VEC, 32'h0000_0000, PC value held during and immediately after reset.
STEP, 4, sequential PC increment in bytes.
STALL_W, 6, width of the pipeline stall vector; only bit 0 is used here.
BTB_EN, 1, 1 enables prediction; 0 forces pred_taken=0 and no BTB state is built.
BTB_DEPTH, 16, number of BTB entries; power of 2, minimum 2.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  reset, asynchronous, active-high.
stall  in  STALL_W  pipeline stall vector; stall[0]=1 freezes the PC.
ex_redirect  in  1  EX-stage mispredict or flush; load ex_redirect_addr.
ex_redirect_addr  in  ADDR_W  corrected PC.
ex_upd  in  1  a branch or jump resolved in EX this cycle; train the BTB.
ex_upd_pc  in  ADDR_W  PC of the resolved branch.
ex_upd_target  in  ADDR_W  resolved target.
ex_upd_taken  in  1  resolved direction.
id_jump  in  1  ID-stage jump (JAL) detected.
id_jump_addr  in  ADDR_W  jump target.
pc  out  ADDR_W  current fetch PC (registered).
chip_enable  out  1  fetch enable (registered).
pred_taken  out  1  combinational: the BTB predicts the instruction at pc is taken.
pred_target  out  ADDR_W  combinational: predicted target; zero when pred_taken=0.

Behaviour:
- Reset (asynchronous, while rst=1):
  - pc=RESET_VEC, chip_enable=0.
  - All BTB valid bits cleared; counters set to 2'b01.
- chip_enable:
  - Set to 1 on the first rising edge with rst=0.
  - Stays 1 until the next rst.
  - While chip_enable=0, pc holds RESET_VEC and all redirect, jump and BTB training inputs are ignored.
- Next-PC priority (evaluated each rising edge with chip_enable=1):
  1. ex_redirect=1: pc<=ex_redirect_addr. Applies even when stall[0]=1, because a flush overrides a stall.
  2. Otherwise, if stall[0]=1: pc holds.
  3. Otherwise, if id_jump=1: pc<=id_jump_addr.
  4. Otherwise, if pred_taken=1: pc<=pred_target.
  5. Otherwise: pc<=pc+STEP, modulo 2^ADDR_W, so pc wraps from all-ones-minus-3 to 0 with no flag.
- Latency: a redirect, jump or prediction asserted in cycle N appears on pc in cycle N+1.
- BTB organisation (BTB_EN=1):
  - IDX_W=log2(BTB_DEPTH); index=pc[IDX_W+1:2]; tag=pc[ADDR_W-1:IDX_W+2].
  - Each entry holds: valid, tag, target[ADDR_W], cnt[2].
  - Lookup on the current pc: hit = valid && tag match; pred_taken = chip_enable && hit && cnt[1].
- BTB training (on the rising edge with ex_upd=1 and chip_enable=1):
  - Hit on ex_upd_pc, taken: cnt saturating increment (max 3); target<=ex_upd_target.
  - Hit, not taken: cnt saturating decrement (min 0); target unchanged.
  - Miss, taken: allocate or overwrite the entry with valid=1, new tag, target, cnt=2'b10.
  - Miss, not taken: no change.
- Simultaneous training and lookup to the same index: the lookup sees pre-update contents; there is no bypass.
- ex_upd and ex_redirect are independent; both may be asserted in the same cycle.
- Reset asserted mid-operation: pc, chip_enable and all BTB state return to reset values immediately, without waiting for a clock edge.
- pc[1:0] is not forced to zero; a misaligned target is passed through unchanged.

Test Plan:
- Reset release: rst 1->0, no other inputs -> chip_enable=0 and pc=RESET_VEC for the first edge; then pc=0x0, 0x4, 0x8 on successive edges.
- Stall versus redirect: stall[0]=1 with id_jump=1 (addr 0x100) -> pc holds. Same cycle with ex_redirect=1 (addr 0x200) -> pc=0x200 on the next edge.
- Priority: ex_redirect (0x40), id_jump (0x80) and a BTB hit all asserted together -> pc=0x40.
- BTB learning: train PC 0x10 taken, target 0x300 -> at pc=0x10, pred_taken=1, pred_target=0x300, next pc=0x300. Train not-taken twice -> cnt=0, pred_taken=0, next pc=0x14.
- Aliasing: with BTB_DEPTH=16, PC 0x10 is valid. Train 0x50 taken (same index, different tag) -> entry replaced; pc=0x10 now misses.
- Wrap and async reset: pc=0xFFFF_FFFC, no inputs -> pc=0x0. Assert rst between edges -> pc=RESET_VEC and pred_taken=0 at once, and all BTB entries invalid afterwards.
